// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: ROUNDS_PER_CYCLE rounds per clock, valid/ready
// handshake on both sides, opaque tag passthrough and optional SHA-256d second pass.
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_block,
  input  logic [255:0]     in_hprev,
  input  logic             in_double,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_hash,
  output logic [TAG_W-1:0] out_tag
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [6:0] LAST = 7'(64 - R);

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  // Tail of the padded second block for a 256-bit message (length = 0x100 bits).
  localparam logic [31:0] PAD [0:7] = '{
    32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000100
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t           state;
  logic [6:0]       cnt;
  logic             second;
  logic             dbl;
  logic [TAG_W-1:0] tag;
  logic [31:0]      work [0:7];
  logic [31:0]      hcopy [0:7];
  logic [31:0]      win [0:15];

  logic [31:0] work_next [0:7];
  logic [31:0] win_next [0:15];
  logic [31:0] ext [0:15+R];
  logic [31:0] st [0:7];
  logic [31:0] digest [0:7];
  logic [31:0] t1, t2;
  logic [5:0]  kidx;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  assign in_ready = (state == IDLE);

  // ext holds the current window followed by the R words it slides in; later words
  // may depend on earlier new ones, so the expansion is chained within the cycle.
  always_comb begin
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int k = 0; k < 16; k++) ext[k] = win[k];
    for (int j = 0; j < R; j++)
      ext[16+j] = sig1(ext[j+14]) + ext[j+9] + sig0(ext[j+1]) + ext[j];
    for (int k = 0; k < 8; k++) st[k] = work[k];
    for (int i = 0; i < R; i++) begin
      kidx  = cnt[5:0] + 6'(i);
      t1    = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[kidx] + ext[i];
      t2    = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
      st[7] = st[6];
      st[6] = st[5];
      st[5] = st[4];
      st[4] = st[3] + t1;
      st[3] = st[2];
      st[2] = st[1];
      st[1] = st[0];
      st[0] = t1 + t2;
    end
    for (int k = 0; k < 8; k++) work_next[k] = st[k];
    for (int k = 0; k < 16; k++) win_next[k] = ext[k+R];
    for (int k = 0; k < 8; k++) digest[k] = hcopy[k] + work[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      second    <= 1'b0;
      dbl       <= 1'b0;
      tag       <= '0;
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_tag   <= '0;
      for (int k = 0; k < 8; k++) begin
        work[k]  <= '0;
        hcopy[k] <= '0;
      end
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int k = 0; k < 8; k++) begin
            work[k]  <= in_hprev[255-32*k -: 32];
            hcopy[k] <= in_hprev[255-32*k -: 32];
          end
          for (int k = 0; k < 16; k++) win[k] <= in_block[511-32*k -: 32];
          dbl    <= in_double;
          tag    <= in_tag;
          cnt    <= '0;
          second <= 1'b0;
          state  <= ROUND;
        end
        ROUND: begin
          for (int k = 0; k < 8; k++) work[k] <= work_next[k];
          for (int k = 0; k < 16; k++) win[k] <= win_next[k];
          cnt <= cnt + 7'(R);
          if (cnt == LAST) state <= FINAL;
        end
        FINAL: if (dbl && !second) begin
          for (int k = 0; k < 8; k++) begin
            work[k]    <= IV[k];
            hcopy[k]   <= IV[k];
            win[k]     <= digest[k];
            win[8+k]   <= PAD[k];
          end
          second <= 1'b1;
          cnt    <= '0;
          state  <= ROUND;
        end else begin
          for (int k = 0; k < 8; k++) out_hash[255-32*k -: 32] <= digest[k];
          out_tag   <= tag;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: five instances (R = 1,2,4,8,16) run the same jobs in
// lockstep; digests are checked against known vectors and a plain SHA-256 model.
module tb_sha256_iter_core;
  localparam int NI = 5;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_HASH =
    256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
  localparam logic [255:0] ABC_DHASH =
    256'h4F8B42C22DD3729B519BA6F68D2DA7CC5B2D606D05DAED5AD5128CC03E6C6358;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_double, out_ready;
  logic [511:0]  in_block;
  logic [255:0]  in_hprev;
  logic [31:0]   in_tag;
  logic [NI-1:0] in_ready, out_valid;
  logic [255:0]  out_hash [NI];
  logic [31:0]   out_tag [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << gi), .TAG_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready[gi]),
        .in_block(in_block), .in_hprev(in_hprev), .in_double(in_double), .in_tag(in_tag),
        .out_valid(out_valid[gi]), .out_ready(out_ready),
        .out_hash(out_hash[gi]), .out_tag(out_tag[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hv;
    for (int t = 0; t < 64; t++) begin
      x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1;
      d = c; c = b; b = a; a = x1 + x2;
    end
    res = {a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = res[255-32*i -: 32] + hv[255-32*i -: 32];
    return res;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] hv, input logic [511:0] blk, input logic dbl);
    logic [255:0] d1;
    d1 = compress(hv, blk);
    return dbl ? compress(IV256, {d1, 32'h80000000, 192'h0, 32'h00000100}) : d1;
  endfunction

  task automatic scramble();
    in_block  = {16{$urandom()}};
    in_hprev  = {8{$urandom()}};
    in_double = 1'($urandom_range(0, 1));
    in_tag    = $urandom();
    in_valid  = 1'($urandom_range(0, 1));
  endtask

  // One job on all instances: accept together, wait for every digest, optional
  // back-pressure window, then a single shared output handshake.
  task automatic run_job(input string name, input logic [511:0] blk, input logic [255:0] hv,
                         input logic dbl, input logic [31:0] tg, input logic [255:0] exp, input int hold);
    int lat [NI];
    int k;
    logic [255:0] held_hash [NI];
    logic [31:0]  held_tag [NI];
    check({name, ":in_ready_idle"}, in_ready, {NI{1'b1}});
    in_block = blk; in_hprev = hv; in_double = dbl; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < NI; i++) lat[i] = -1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (out_valid != {NI{1'b1}} && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (k == 2) out_ready = 1'b0;
      for (int i = 0; i < NI; i++) if (out_valid[i] && lat[i] < 0) lat[i] = k;
      scramble();
    end
    in_valid = 1'b0;
    check({name, ":all_valid"}, out_valid, {NI{1'b1}});
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s:hash R=%0d", name, 1 << i), out_hash[i], exp);
      check($sformatf("%s:tag R=%0d", name, 1 << i), out_tag[i], tg);
      check($sformatf("%s:latency R=%0d", name, 1 << i), lat[i],
            dbl ? 2 * (64 >> i) + 2 : (64 >> i) + 1);
      held_hash[i] = out_hash[i];
      held_tag[i]  = out_tag[i];
    end
    for (int c = 0; c < hold; c++) begin
      scramble();
      @(posedge clk); #1;
      check($sformatf("%s:bp_valid c%0d", name, c), out_valid, {NI{1'b1}});
      check($sformatf("%s:bp_in_ready c%0d", name, c), in_ready, '0);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("%s:bp_hash R=%0d c%0d", name, 1 << i, c), out_hash[i], held_hash[i]);
        check($sformatf("%s:bp_tag R=%0d c%0d", name, 1 << i, c), out_tag[i], held_tag[i]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ":post_hs_valid"}, out_valid, '0);
    check({name, ":post_hs_ready"}, in_ready, {NI{1'b1}});
    $display("job %s dbl=%0d tag=%h expected=%h", name, dbl, tg, exp);
  endtask

  initial begin
    logic [511:0] rb;
    logic [255:0] rh;
    logic         rd;
    logic [31:0]  rt;
    reset = 1'b1; in_valid = 1'b0; in_double = 1'b0; out_ready = 1'b0;
    in_block = '0; in_hprev = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:out_valid", out_valid, '0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset:out_hash R=%0d", 1 << i), out_hash[i], '0);
      check($sformatf("reset:out_tag R=%0d", 1 << i), out_tag[i], '0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("reset:in_ready", in_ready, {NI{1'b1}});

    run_job("abc_single", ABC_BLOCK, IV256, 1'b0, 32'hDEADBEEF, ABC_HASH, 0);
    run_job("abc_double", ABC_BLOCK, IV256, 1'b1, 32'h12345678, ABC_DHASH, 20);

    for (int j = 0; j < 6; j++) begin
      for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom();
      for (int w = 0; w < 8; w++) rh[255-32*w -: 32] = $urandom();
      rd = 1'($urandom_range(0, 1));
      rt = $urandom();
      run_job($sformatf("rand%0d", j), rb, rh, rd, rt, model(rh, rb, rd), $urandom_range(0, 3));
    end

    // Abort a double job during the second pass of the R=1 instance.
    in_block = ABC_BLOCK; in_hprev = IV256; in_double = 1'b1; in_tag = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset:out_valid", out_valid, '0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midreset:out_hash R=%0d", 1 << i), out_hash[i], '0);
      check($sformatf("midreset:out_tag R=%0d", 1 << i), out_tag[i], '0);
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("midreset:in_ready", in_ready, {NI{1'b1}});
    @(posedge clk); #1;
    run_job("abc_after_reset", ABC_BLOCK, IV256, 1'b0, 32'h0BADF00D, ABC_HASH, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
